// File: rtl/ascii_hex_word_parser.sv
// ascii_hex_word_parser
// Packs a stream of ASCII hex characters (most-significant digit first) into
// words of NUM_DIGITS nibbles. A completed word appears on out/word_len with a
// one-cycle ready pulse. A non-hex byte gives a one-cycle error pulse and
// discards the partial word.
// Build option ASCII_HEX_DELIM_EN: space, CR, LF and ',' close an open word
// early (right-aligned, zero-extended) and are ignored when no word is open.
module ascii_hex_word_parser #(
  parameter  int NUM_DIGITS = 8,
  localparam int CNT_W      = $clog2(NUM_DIGITS + 1),
  localparam int W          = 4 * NUM_DIGITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    data_valid,
  input  logic [7:0]              transmitted_byte,
  output logic                    ready,
  output logic [4*NUM_DIGITS-1:0] out,
  output logic [CNT_W-1:0]        word_len,
  output logic                    error
);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_bad_num_digits
    $error("ascii_hex_word_parser: NUM_DIGITS must be in 2..16");
  end

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EMIT
  } state_t;

  state_t           state_q;
  logic [W-1:0]     acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     out_q;
  logic [CNT_W-1:0] len_q;
  logic             ready_q;
  logic             error_q;

  logic             is_hex;
  logic             is_delim;
  logic [3:0]       nibble;

  // Character decode: hex digit value, hex flag and delimiter flag.
  always_comb begin
    is_hex   = 1'b0;
    is_delim = 1'b0;
    nibble   = '0;
    if (transmitted_byte >= 8'h30 && transmitted_byte <= 8'h39) begin
      is_hex = 1'b1;
      nibble = 4'(transmitted_byte - 8'h30);
    end else if (transmitted_byte >= 8'h41 && transmitted_byte <= 8'h46) begin
      is_hex = 1'b1;
      nibble = 4'(transmitted_byte - 8'h37);
    end else if (transmitted_byte >= 8'h61 && transmitted_byte <= 8'h66) begin
      is_hex = 1'b1;
      nibble = 4'(transmitted_byte - 8'h57);
    end
`ifdef ASCII_HEX_DELIM_EN
    if (transmitted_byte == 8'h20 || transmitted_byte == 8'h0D ||
        transmitted_byte == 8'h0A || transmitted_byte == 8'h2C) begin
      is_delim = 1'b1;
    end
`endif
  end

  // Word assembly FSM with registered ready/error pulses and held out/word_len.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      len_q   <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        // EMIT publishes the finished word and then treats any incoming byte
        // exactly like IDLE, so back-to-back words lose no character.
        IDLE, EMIT: begin
          if (state_q == EMIT) begin
            out_q   <= acc_q;
            len_q   <= cnt_q;
            ready_q <= 1'b1;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
          if (data_valid) begin
            if (is_hex) begin
              acc_q   <= {{(W-4){1'b0}}, nibble};
              cnt_q   <= CNT_W'(1);
              state_q <= COLLECT;
            end else if (!is_delim) begin
              error_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (data_valid) begin
            if (is_hex) begin
              acc_q <= {acc_q[W-5:0], nibble};
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
                state_q <= EMIT;
              end
            end else if (is_delim) begin
              state_q <= EMIT;
            end else begin
              error_q <= 1'b1;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign error    = error_q;
  assign out      = out_q;
  assign word_len = len_q;

endmodule

// File: tb/tb_ascii_hex_word_parser.sv
// Testbench for ascii_hex_word_parser: two instances (8-digit and 2-digit words)
// driven with directed and random character streams; a stream-level model
// queues expected ready/error events, and a monitor checks them as they appear.
module tb_ascii_hex_word_parser;

`ifdef ASCII_HEX_DELIM_EN
  localparam bit DELIM_EN = 1'b1;
`else
  localparam bit DELIM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        dv0, dv1;
  logic [7:0]  bt0, bt1;
  logic        rdy8, err8, rdy2, err2;
  logic [31:0] out8;
  logic [7:0]  out2;
  logic [3:0]  len8;
  logic [1:0]  len2;

  always #5 clk = ~clk;

  ascii_hex_word_parser #(.NUM_DIGITS(8)) u_dut8 (
    .clk(clk), .reset(reset), .data_valid(dv0), .transmitted_byte(bt0),
    .ready(rdy8), .out(out8), .word_len(len8), .error(err8)
  );

  ascii_hex_word_parser #(.NUM_DIGITS(2)) u_dut2 (
    .clk(clk), .reset(reset), .data_valid(dv1), .transmitted_byte(bt1),
    .ready(rdy2), .out(out2), .word_len(len2), .error(err2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [63:0] val;
    int          len;
    int          cyc;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  logic [63:0] mval [2];
  int          mcnt [2];

  int          n_total = 0;
  int          n_bad   = 0;
  logic [63:0] mon_last [2];
  int          mon_len  [2];
  bit          rst_prev  = 1'b1;
  bit          drain_req = 1'b0;
  bit          drained   = 1'b0;

  // ---------------- reference model ----------------
  function automatic int hexval(input logic [7:0] c);
    string      digs = "0123456789abcdef";
    logic [7:0] lc   = c;
    if (c >= 8'h41 && c <= 8'h5A) lc = c + 8'd32;
    for (int i = 0; i < 16; i++) if (digs[i] == lc) return i;
    return -1;
  endfunction

  function automatic bit is_delim(input logic [7:0] c);
    return DELIM_EN && (c == 8'h20 || c == 8'h0D || c == 8'h0A || c == 8'h2C);
  endfunction

  task automatic push_ev(input int d, input bit is_err, input logic [63:0] v,
                         input int l, input int c);
    ev_t e;
    e.is_err = is_err; e.val = v; e.len = l; e.cyc = c;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Called at the negedge where the character is presented: it is accepted on
  // the next edge, an error shows one cycle later, a finished word two.
  task automatic model_char(input int d, input logic [7:0] c);
    int h = hexval(c);
    int n = (d == 0) ? 8 : 2;
    if (h >= 0) begin
      mval[d] = (mval[d] << 4) | 64'(h);
      mcnt[d] = mcnt[d] + 1;
      if (mcnt[d] == n) begin
        push_ev(d, 1'b0, mval[d], mcnt[d], cyc + 2);
        mval[d] = '0; mcnt[d] = 0;
      end
    end else if (is_delim(c)) begin
      if (mcnt[d] > 0) begin
        push_ev(d, 1'b0, mval[d], mcnt[d], cyc + 2);
        mval[d] = '0; mcnt[d] = 0;
      end
    end else begin
      push_ev(d, 1'b1, '0, 0, cyc + 1);
      mval[d] = '0; mcnt[d] = 0;
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic send(input int d, input logic [7:0] c, input int gap);
    model_char(d, c);
    if (d == 0) begin dv0 = 1'b1; bt0 = c; end
    else        begin dv1 = 1'b1; bt1 = c; end
    @(negedge clk);
    if (d == 0) dv0 = 1'b0; else dv1 = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_str(input int d, input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send(d, s[i], gap);
  endtask

  task automatic do_reset();
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    mval[0] = '0; mval[1] = '0; mcnt[0] = 0; mcnt[1] = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [7:0] rand_char();
    string hexs = "0123456789abcdefABCDEF";
    string dl   = " \n,";
    string bad  = "GgZz/:@`~.";
    int    r    = $urandom_range(0, 99);
    if (r < 70) return hexs[$urandom_range(0, 21)];
    if (r < 80) begin
      int k = $urandom_range(0, 3);
      return (k == 3) ? 8'h0D : dl[k];
    end
    if (r < 92) return bad[$urandom_range(0, 9)];
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic rand_stream(input int d, input int nchars, input int maxgap);
    for (int i = 0; i < nchars; i++) send(d, rand_char(), $urandom_range(1, maxgap));
  endtask

  // ---------------- monitor / scoreboard ----------------
  function automatic int front_cyc(input int d);
    if (d == 0) return (q0.size() > 0) ? q0[0].cyc : -1;
    return (q1.size() > 0) ? q1[0].cyc : -1;
  endfunction

  task automatic pop(input int d, output bit ok, output ev_t e);
    ok = 1'b0; e.is_err = 1'b0; e.val = '0; e.len = 0; e.cyc = 0;
    if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
    if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
  endtask

  task automatic check_dut(input int d, input logic rdy, input logic err,
                           input logic [63:0] ov, input int lv);
    ev_t e;
    bit  ok;
    while (front_cyc(d) >= 0 && front_cyc(d) < cyc) begin
      pop(d, ok, e);
      n_total++; n_bad++;
      $display("FAIL missing_pulse d%0d: got no %s at cyc %0d, required one (err=%0d val=%h)",
               d, e.is_err ? "error" : "ready", e.cyc, e.is_err, e.val);
    end
    if (rdy) begin
      pop(d, ok, e);
      n_total++;
      if (!ok || e.is_err || e.val != ov || e.len != lv || e.cyc != cyc) begin
        n_bad++;
        $display("FAIL ready_word d%0d cyc=%0d: got out=%h len=%0d, required out=%h len=%0d at cyc %0d (expected=%0d err_exp=%0d)",
                 d, cyc, ov, lv, e.val, e.len, e.cyc, ok, e.is_err);
      end
      if (ok && !e.is_err) begin mon_last[d] = e.val; mon_len[d] = e.len; end
    end else begin
      n_total++;
      if (ov != mon_last[d] || lv != mon_len[d]) begin
        n_bad++;
        $display("FAIL hold d%0d cyc=%0d: got out=%h len=%0d, required out=%h len=%0d",
                 d, cyc, ov, lv, mon_last[d], mon_len[d]);
      end
    end
    if (err) begin
      pop(d, ok, e);
      n_total++;
      if (!ok || !e.is_err || e.cyc != cyc) begin
        n_bad++;
        $display("FAIL error_pulse d%0d cyc=%0d: got error=1, required error at cyc %0d (expected=%0d err_exp=%0d)",
                 d, cyc, e.cyc, ok, e.is_err);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mon_last[0] = '0; mon_last[1] = '0; mon_len[0] = 0; mon_len[1] = 0;
      rst_prev = 1'b1;
    end else begin
      if (rst_prev) begin
        n_total++;
        if (rdy8 || err8 || out8 != '0 || len8 != '0 ||
            rdy2 || err2 || out2 != '0 || len2 != '0) begin
          n_bad++;
          $display("FAIL reset_state: got rdy=%b/%b err=%b/%b out=%h/%h len=%0d/%0d, required all zero",
                   rdy8, rdy2, err8, err2, out8, out2, len8, len2);
        end
      end
      rst_prev = 1'b0;
      check_dut(0, rdy8, err8, {32'b0, out8}, int'(len8));
      check_dut(1, rdy2, err2, {56'b0, out2}, int'(len2));
      if (drain_req && !drained) begin
        drained = 1'b1;
        n_total++;
        if (q0.size() != 0 || q1.size() != 0) begin
          n_bad++;
          $display("FAIL drain: got %0d/%0d outstanding expected events, required 0/0",
                   q0.size(), q1.size());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; dv0 = 1'b0; dv1 = 1'b0; bt0 = '0; bt1 = '0;
    mval[0] = '0; mval[1] = '0; mcnt[0] = 0; mcnt[1] = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    send_str(0, "DEADbeef", 3);
    send_str(1, "7fA5", 1);
    repeat (3) @(negedge clk);
    send_str(0, "12G4", 2);
    send_str(0, "00000001", 1);

    do_reset();
    send_str(0, "ABC", 1);
    do_reset();
    send_str(0, "11223344", 2);

    send_str(0, "1F", 1);
    send(0, 8'h0D, 1);
    repeat (3) @(negedge clk);
    send(0, 8'h0A, 2);
    send_str(0, "1F ", 1);
    send_str(1, "3", 1);
    send(1, 8'h2C, 1);
    send_str(1, "9cz", 1);
    repeat (3) @(negedge clk);

    fork
      rand_stream(0, 250, 3);
      rand_stream(1, 250, 2);
    join

    repeat (6) @(negedge clk);
    drain_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
